// File: rtl/distance_uart_reporter.sv
// Formats the ultrasonic distance as "DDDcm\r\n" and streams it byte by byte into the UART transmitter.
// Frames come from a request pulse, the auto-report period, or a request that arrived while a frame was running.

module distance_uart_reporter_chk (
   input logic clk,
   input logic reset,
   input logic tx_start,
   input logic busy
);

   // A start is a single-cycle pulse; the next byte always waits for a done.
   a_start_single : assert property (@(posedge clk) disable iff (!reset) tx_start |=> !tx_start);
   a_start_busy   : assert property (@(posedge clk) disable iff (!reset) tx_start |-> busy);

endmodule

module distance_uart_reporter #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned PERIOD_MS = 500,
   parameter int unsigned MAX_CM    = 400
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] i_distance,
   input  logic       i_req,
   input  logic       i_auto_en,
   input  logic       i_tx_done,
   output logic       o_tx_start,
   output logic [7:0] o_tx_data,
   output logic       o_busy
);

   localparam int unsigned      PERIOD_CYC  = CLK_HZ / 32'd1000 * PERIOD_MS;
   localparam int unsigned      CNT_W       = (PERIOD_CYC > 32'd1) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
   localparam logic [9:0]       MAX_CM_L    = 10'(MAX_CM);
   localparam logic [3:0]       CONV_LAST   = 4'd8;
   localparam logic [2:0]       IDX_LAST    = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_SEND = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [CNT_W-1:0] period_cnt_r;
   logic             tick_s;
   logic             trigger_s;
   logic             accept_s;
   logic             over_s;
   logic             pending_r;
   logic [8:0]       dist_r;
   logic [20:0]      dd_r;
   logic [20:0]      dd_next_s;
   logic [11:0]      bcd_src_s;
   logic [3:0]       conv_cnt_r;
   logic [2:0]       idx_r;
   logic [2:0]       idx_next_s;
   logic             tx_start_r;
   logic [7:0]       tx_data_r;
   logic             busy_r;

   // One double-dabble step on {hundreds, tens, ones, remaining binary}: adjust digits >= 5, then shift.
   function automatic logic [20:0] dd_step(input logic [20:0] v);
      logic [20:0] t;
      t = v;
      for (int d = 0; d < 3; d++) begin
         if (t[9 + 4*d +: 4] >= 4'd5) begin
            t[9 + 4*d +: 4] = t[9 + 4*d +: 4] + 4'd3;
         end else begin
            t[9 + 4*d +: 4] = t[9 + 4*d +: 4];
         end
      end
      return {t[19:0], 1'b0};
   endfunction

   // Byte idx of the line; leading zeros blank to spaces but the ones digit is always a numeral.
   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [11:0] bcd,
                                             input logic over);
      logic [7:0] b;
      case (idx)
         3'd0: begin
            if (over)                    b = 8'h2D;
            else if (bcd[11:8] == 4'd0)  b = 8'h20;
            else                         b = {4'h3, bcd[11:8]};
         end
         3'd1: begin
            if (over)                                      b = 8'h2D;
            else if ((bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)) b = 8'h20;
            else                                           b = {4'h3, bcd[7:4]};
         end
         3'd2: begin
            if (over) b = 8'h2D;
            else      b = {4'h3, bcd[3:0]};
         end
         3'd3:    b = 8'h63;
         3'd4:    b = 8'h6D;
         3'd5:    b = 8'h0D;
         3'd6:    b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign tick_s    = i_auto_en & (period_cnt_r == PERIOD_LAST);
   assign trigger_s = i_req | tick_s | pending_r;
   assign over_s    = ({1'b0, dist_r} > MAX_CM_L);
   assign dd_next_s = dd_step(dd_r);

   // The last conversion step lands on the same edge that loads byte 0, so use the step result then.
   always_comb begin
      bcd_src_s = dd_r[20:9];
      if (state_r == ST_CONV) begin
         bcd_src_s = dd_next_s[20:9];
      end else begin
         bcd_src_s = dd_r[20:9];
      end
   end

   // Auto-report period counter, held at zero while auto mode is off.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_cnt_r <= {CNT_W{1'b0}};
      end else if (!i_auto_en) begin
         period_cnt_r <= {CNT_W{1'b0}};
      end else if (period_cnt_r == PERIOD_LAST) begin
         period_cnt_r <= {CNT_W{1'b0}};
      end else begin
         period_cnt_r <= period_cnt_r + CNT_ONE;
      end
   end

   // Triggers arriving during a frame collapse into one pending frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_r <= 1'b0;
      end else if (state_r != ST_IDLE) begin
         if (i_req | tick_s) begin
            pending_r <= 1'b1;
         end
      end else if (accept_s) begin
         pending_r <= 1'b0;
      end
   end

   // Next-state logic; i_tx_done only matters while waiting on a byte.
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      accept_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (trigger_s) begin
               accept_s     = 1'b1;
               idx_next_s   = 3'd0;
               state_next_s = ST_CONV;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CONV: begin
            if (conv_cnt_r == CONV_LAST) begin
               idx_next_s   = 3'd0;
               state_next_s = ST_SEND;
            end else begin
               state_next_s = ST_CONV;
            end
         end
         ST_SEND: begin
            state_next_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_tx_done) begin
               if (idx_r < IDX_LAST) begin
                  idx_next_s   = idx_r + 3'd1;
                  state_next_s = ST_SEND;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, sample capture and binary-to-BCD shift register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         idx_r      <= 3'd0;
         dist_r     <= 9'd0;
         dd_r       <= 21'd0;
         conv_cnt_r <= 4'd0;
      end else begin
         state_r <= state_next_s;
         idx_r   <= idx_next_s;
         if (accept_s) begin
            dist_r     <= i_distance;
            dd_r       <= {12'd0, i_distance};
            conv_cnt_r <= 4'd0;
         end else if (state_r == ST_CONV) begin
            dd_r       <= dd_next_s;
            conv_cnt_r <= conv_cnt_r + 4'd1;
         end
      end
   end

   // Registered outputs decoded from the upcoming state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_start_r <= 1'b0;
         tx_data_r  <= 8'h00;
         busy_r     <= 1'b0;
      end else begin
         tx_start_r <= (state_next_s == ST_SEND);
         busy_r     <= (state_next_s != ST_IDLE);
         if (state_next_s == ST_SEND) begin
            tx_data_r <= frame_byte(idx_next_s, bcd_src_s, over_s);
         end
      end
   end

   assign o_tx_start = tx_start_r;
   assign o_tx_data  = tx_data_r;
   assign o_busy     = busy_r;

   distance_uart_reporter_chk u_chk (
      .clk      (clk),
      .reset    (reset),
      .tx_start (tx_start_r),
      .busy     (busy_r)
   );

endmodule

// File: tb/tb_distance_uart_reporter.sv
// Bench for distance_uart_reporter: a UART responder acknowledges each byte 20 cycles after its start,
// and a scoreboard of expected bytes is filled when frames are requested and drained on every start.

module tb_distance_uart_reporter;

   logic       clk;
   logic       rst_n;
   logic [8:0] i_distance;
   logic       i_req;
   logic       i_auto_en;
   logic       i_tx_done;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       o_busy;

   logic       resp_done = 1'b0;
   logic       spur_done = 1'b0;
   logic [7:0] q[$];
   int         start_log[$];
   int         fall_log[$];
   int         cyc = 0;
   int         cd = 0;
   int         done_cnt = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   int         req_cyc = 0;
   int         base = 0;
   logic [7:0] last_byte = 8'h00;
   logic [7:0] exp_b;
   logic       prev_busy = 1'b0;

   assign i_tx_done = resp_done | spur_done;

   distance_uart_reporter #(
      .CLK_HZ    (1_000_000),
      .PERIOD_MS (1),
      .MAX_CM    (400)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .i_distance (i_distance),
      .i_req      (i_req),
      .i_auto_en  (i_auto_en),
      .i_tx_done  (i_tx_done),
      .o_tx_start (o_tx_start),
      .o_tx_data  (o_tx_data),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
   endtask

   function automatic void push_frame(input int d);
      int h, t, o;
      if (d > 400) begin
         repeat (3) q.push_back(8'h2D);
      end else begin
         h = d / 100;
         t = (d / 10) % 10;
         o = d % 10;
         q.push_back((h == 0) ? 8'h20 : 8'(48 + h));
         q.push_back((h == 0 && t == 0) ? 8'h20 : 8'(48 + t));
         q.push_back(8'(48 + o));
      end
      q.push_back(8'h63);
      q.push_back(8'h6D);
      q.push_back(8'h0D);
      q.push_back(8'h0A);
   endfunction

   task automatic send_req(input logic [8:0] d);
      @(negedge clk);
      i_distance = d;
      i_req      = 1'b1;
      req_cyc    = cyc;
      push_frame(int'(d));
      @(negedge clk);
      i_req = 1'b0;
   endtask

   task automatic spur_pulse();
      @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt >= target && !o_busy && q.size() == 0) break;
      end
      chk("frame_done", 32'(done_cnt), 32'(target));
   endtask

   // UART responder and scoreboard drain, sampled just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         resp_done = 1'b0;
         if (!rst_n) begin
            cd        = 0;
            prev_busy = 1'b0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  resp_done = 1'b1;
                  done_cnt++;
                  chk("data_hold", 32'(o_tx_data), 32'(last_byte));
               end
            end
            if (o_tx_start) begin
               chk("start_after_done", 32'(cd), 32'd0);
               chk("sb_has_entry", 32'(q.size() != 0), 32'd1);
               if (q.size() != 0) begin
                  exp_b = q.pop_front();
                  chk("tx_byte", 32'(o_tx_data), 32'(exp_b));
               end
               last_byte = o_tx_data;
               start_log.push_back(cyc);
               cd = 20;
            end
            if (prev_busy && !o_busy) fall_log.push_back(cyc);
            prev_busy = o_busy;
         end
      end
   end

   initial begin
      int dl[4] = '{7, 0, 400, 401};
      rst_n      = 1'b0;
      i_distance = 9'd0;
      i_req      = 1'b0;
      i_auto_en  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_start", 32'(o_tx_start), 32'd0);
      chk("rst_data", 32'(o_tx_data), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      rst_n = 1'b1;

      // Single frame: byte values, start latency and busy fall.
      base = done_cnt;
      start_log.delete();
      fall_log.delete();
      send_req(9'd123);
      @(posedge clk);
      #2;
      chk("busy_rise", 32'(o_busy), 32'd1);
      wait_done(base + 7, 400);
      chk("t1_starts", 32'(start_log.size()), 32'd7);
      chk("t1_first_start", 32'((start_log.size() > 0 ? start_log[0] : 0) - req_cyc), 32'd10);
      chk("t1_busy_fall", 32'((fall_log.size() > 0 ? fall_log[0] : 0) -
                              (start_log.size() > 6 ? start_log[6] : 0)), 32'd21);

      // Formatting corners, with stray done pulses in IDLE and CONV on the first frame.
      for (int i = 0; i < 4; i++) begin
         base = done_cnt;
         start_log.delete();
         if (i == 0) spur_pulse();
         send_req(9'(dl[i]));
         if (i == 0) begin
            @(negedge clk);
            spur_pulse();
         end
         wait_done(base + 7, 400);
         chk("t2_starts", 32'(start_log.size()), 32'd7);
      end

      // Auto mode: three periods inside the enabled window, nothing afterwards.
      chk("t3_cnt_idle", 32'(dut.period_cnt_r), 32'd0);
      base = done_cnt;
      start_log.delete();
      @(negedge clk);
      i_distance = 9'd250;
      repeat (3) push_frame(250);
      i_auto_en = 1'b1;
      repeat (3500) @(negedge clk);
      i_auto_en = 1'b0;
      wait_done(base + 21, 600);
      chk("t3_starts", 32'(start_log.size()), 32'd21);
      repeat (1500) @(negedge clk);
      chk("t3_starts_off", 32'(start_log.size()), 32'd21);
      chk("t3_cnt_off", 32'(dut.period_cnt_r), 32'd0);

      // Three requests while busy collapse to one frame carrying the distance current at restart.
      base = done_cnt;
      start_log.delete();
      fall_log.delete();
      send_req(9'd55);
      push_frame(9);
      for (int j = 0; j < 3; j++) begin
         repeat (25) @(negedge clk);
         i_distance = (j == 0) ? 9'd200 : ((j == 1) ? 9'd300 : 9'd9);
         i_req      = 1'b1;
         @(negedge clk);
         i_req = 1'b0;
      end
      wait_done(base + 14, 800);
      chk("t4_starts", 32'(start_log.size()), 32'd14);
      chk("t4_restart", 32'((start_log.size() > 7 ? start_log[7] : 0) -
                            (fall_log.size() > 0 ? fall_log[0] : 0)), 32'd10);
      chk("t4_fall", 32'((fall_log.size() > 0 ? fall_log[0] : 0) -
                         (start_log.size() > 6 ? start_log[6] : 0)), 32'd21);

      // Reset in WAIT after the second byte aborts the frame; nothing resumes on release.
      start_log.delete();
      send_req(9'd321);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (start_log.size() >= 2) break;
      end
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_start", 32'(o_tx_start), 32'd0);
      chk("t5_data", 32'(o_tx_data), 32'd0);
      chk("t5_busy", 32'(o_busy), 32'd0);
      q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      start_log.delete();
      repeat (300) @(negedge clk);
      chk("t5_no_start", 32'(start_log.size()), 32'd0);
      chk("t5_idle", 32'(o_busy), 32'd0);
      base = done_cnt;
      send_req(9'd45);
      wait_done(base + 7, 400);
      chk("t5_starts", 32'(start_log.size()), 32'd7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #600_000;
      $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
